// File: rtl/partialsums_accum.sv
// rtl/partialsums_accum.sv - per-column partial-sum accumulator with independent column row counters.
// Each column owns its own array and write pipeline; a two-stage read port shares the clock.
module partialsums_accum #(
  parameter int NCOL = 32,
  parameter int PW   = 16,
  parameter int AW   = 11,
  parameter int BW   = 6,
  parameter bit SAT  = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic                      accumulate,
  input  logic [AW-1:0]             address_start,
  input  logic [BW-1:0]             batch,
  input  logic [$clog2(NCOL)-1:0]   last_col,
  input  logic [NCOL*PW-1:0]        partialsum_out,
  input  logic [NCOL-1:0]           partialsum_out_valid,
  input  logic                      s_en,
  input  logic [AW-1:0]             s_addr,
  output logic [NCOL*PW-1:0]        s_dout,
  output logic                      busy,
  output logic                      done,
  output logic                      sat_flag
);

  localparam int LCW = $clog2(NCOL);
  localparam logic [PW-1:0] PMAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic [PW-1:0] PMIN = {1'b1, {(PW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             acc_q;
  logic [AW-1:0]    addr_q;
  logic [BW-1:0]    batch_q;
  logic [LCW-1:0]   last_col_q;
  logic             sat_q;
  logic             rd_valid_q;
  logic             start_ok;

  wire [NCOL-1:0]    accept;
  wire [NCOL-1:0]    fin;
  wire [NCOL-1:0]    ovf;
  wire [NCOL-1:0]    wr_pending;
  wire [NCOL*PW-1:0] rd_data;

  assign start_ok = start && (state_q != S_RUN);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign sat_flag = sat_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      acc_q      <= 1'b0;
      addr_q     <= '0;
      batch_q    <= '0;
      last_col_q <= '0;
      sat_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      s_dout     <= '0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= s_en;
      if (rd_valid_q) begin
        s_dout <= rd_data;
      end
      if (start_ok) begin
        acc_q      <= accumulate;
        addr_q     <= address_start;
        batch_q    <= batch;
        last_col_q <= last_col;
        sat_q      <= 1'b0;
      end else if (|(accept & ovf)) begin
        sat_q <= 1'b1;
      end
    end
  end

  // The job ends only once every active column has finished and its last write has committed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if ((&fin) && !(|wr_pending)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar c = 0; c < NCOL; c++) begin : g_col
    localparam logic [LCW-1:0] CIDX = LCW'(c);

    logic [PW-1:0] mem [2**AW];
    logic [BW-1:0] cnt_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic [PW-1:0] wr_data_q;
    logic [PW-1:0] rd_q;
    logic [AW-1:0] row;
    logic [PW-1:0] din;
    logic [PW-1:0] old;
    logic [PW-1:0] nv;
    logic [PW:0]   sum;
    logic          o;

    assign row = addr_q + AW'(cnt_q);
    assign din = partialsum_out[c*PW +: PW];
    assign old = mem[row];

    always_comb begin
      sum = {old[PW-1], old} + {din[PW-1], din};
      o   = acc_q && (sum[PW] ^ sum[PW-1]);
      nv  = din;
      if (acc_q) begin
        nv = sum[PW-1:0];
        if (o && SAT) nv = sum[PW] ? PMIN : PMAX;
      end
    end

    assign fin[c]           = (CIDX > last_col_q) || (cnt_q == batch_q);
    assign accept[c]        = (state_q == S_RUN) && partialsum_out_valid[c] && !fin[c];
    assign ovf[c]           = o;
    assign wr_pending[c]    = wr_en_q;
    assign rd_data[c*PW +: PW] = rd_q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q     <= '0;
        wr_en_q   <= 1'b0;
        wr_addr_q <= '0;
        wr_data_q <= '0;
        rd_q      <= '0;
      end else begin
        if (start_ok) begin
          cnt_q <= '0;
        end else if (accept[c]) begin
          cnt_q <= cnt_q + BW'(1);
        end
        wr_en_q   <= accept[c];
        wr_addr_q <= row;
        wr_data_q <= nv;
        if (s_en) begin
          rd_q <= mem[s_addr];
        end
      end
    end

    // Nonblocking write alongside the read register gives read-first behaviour on a shared row.
    always_ff @(posedge clk) begin
      if (wr_en_q) begin
        mem[wr_addr_q] <= wr_data_q;
      end
    end
  end

endmodule
